// File: rtl/traffic_pkg.sv
// Shared state encoding, direction codes and default phase timings
// for the two-road intersection phase scheduler.
package traffic_pkg;

   typedef enum logic [2:0] {
      S_NSG   = 3'd0,
      S_NSY   = 3'd1,
      S_RED_A = 3'd2,
      S_EWG   = 3'd3,
      S_EWY   = 3'd4,
      S_RED_B = 3'd5,
      S_WALK  = 3'd6
   } state_e;

   localparam logic DIR_NS = 1'b0;
   localparam logic DIR_EW = 1'b1;

   localparam int GREEN_MIN_DEF = 8;
   localparam int GREEN_MAX_DEF = 20;
   localparam int YELLOW_T_DEF  = 3;
   localparam int ALLRED_T_DEF  = 1;
   localparam int WALK_T_DEF    = 6;
   localparam int CNT_W_DEF     = 5;

   // Green state serving the given direction code.
   function automatic state_e green_of(input logic dir);
      return (dir == DIR_EW) ? S_EWG : S_NSG;
   endfunction

endpackage

// File: rtl/traffic_phase_scheduler_phase_timer.sv
// Saturating phase timer: cleared on every state change, then counts up
// and holds at GREEN_MAX-1, exposing the phase-end comparison flags.
module phase_timer
   import traffic_pkg::*;
#(
   parameter int GREEN_MIN = GREEN_MIN_DEF,
   parameter int GREEN_MAX = GREEN_MAX_DEF,
   parameter int YELLOW_T  = YELLOW_T_DEF,
   parameter int ALLRED_T  = ALLRED_T_DEF,
   parameter int WALK_T    = WALK_T_DEF,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt,
   output logic             at_min,
   output logic             at_max,
   output logic             at_yellow,
   output logic             at_allred,
   output logic             at_walk
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clr) begin
         cnt_d = '0;
      end else if (at_max) begin
         cnt_d = cnt_q;
      end
   end

   // NOTE: sequential state is written with <= so every flop samples the
   // pre-edge values of its neighbours, independent of block ordering.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt       = cnt_q;
   assign at_min    = (cnt_q >= CNT_W'(GREEN_MIN - 1));
   assign at_max    = (cnt_q == CNT_W'(GREEN_MAX - 1));
   assign at_yellow = (cnt_q == CNT_W'(YELLOW_T - 1));
   assign at_allred = (cnt_q == CNT_W'(ALLRED_T - 1));
   assign at_walk   = (cnt_q == CNT_W'(WALK_T - 1));

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Two-road intersection sequencer: actuated green, fixed yellow/all-red,
// latched pedestrian walk phase and emergency preemption; Moore lamp decode.
module traffic_phase_scheduler
   import traffic_pkg::*;
#(
   parameter int GREEN_MIN = GREEN_MIN_DEF,
   parameter int GREEN_MAX = GREEN_MAX_DEF,
   parameter int YELLOW_T  = YELLOW_T_DEF,
   parameter int ALLRED_T  = ALLRED_T_DEF,
   parameter int WALK_T    = WALK_T_DEF,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ns_car,
   input  logic       ew_car,
   input  logic       ped_req,
   input  logic       emerg_req,
   input  logic       emerg_dir,
   output logic       NS_green,
   output logic       NS_yellow,
   output logic       NS_red,
   output logic       EW_green,
   output logic       EW_yellow,
   output logic       EW_red,
   output logic       walk,
   output logic [2:0] phase
);

   state_e           state_q;
   state_e           state_d;
   logic             ped_pending_q;
   logic             ped_pending_d;
   logic             next_ew_q;
   logic             next_ew_d;
   logic             clr;
   logic [CNT_W-1:0] cnt;
   logic             at_min;
   logic             at_max;
   logic             at_yellow;
   logic             at_allred;
   logic             at_walk;

   phase_timer #(
      .GREEN_MIN (GREEN_MIN),
      .GREEN_MAX (GREEN_MAX),
      .YELLOW_T  (YELLOW_T),
      .ALLRED_T  (ALLRED_T),
      .WALK_T    (WALK_T),
      .CNT_W     (CNT_W)
   ) u_timer (
      .clk       (clk),
      .reset     (reset),
      .clr       (clr),
      .cnt       (cnt),
      .at_min    (at_min),
      .at_max    (at_max),
      .at_yellow (at_yellow),
      .at_allred (at_allred),
      .at_walk   (at_walk)
   );

   // NOTE: every variable written here gets a default first, so no path
   // through the case leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      next_ew_d = next_ew_q;
      case (state_q)
         S_NSG: begin
            if (emerg_req) begin
               if (emerg_dir == DIR_EW) state_d = S_NSY;
            end else if (at_min && (ew_car || ped_pending_q) && (!ns_car || at_max)) begin
               state_d = S_NSY;
            end
         end
         S_EWG: begin
            if (emerg_req) begin
               if (emerg_dir == DIR_NS) state_d = S_EWY;
            end else if (at_min && (ns_car || ped_pending_q) && (!ew_car || at_max)) begin
               state_d = S_EWY;
            end
         end
         S_NSY: if (at_yellow) state_d = S_RED_A;
         S_EWY: if (at_yellow) state_d = S_RED_B;
         S_RED_A: begin
            if (at_allred) begin
               if (emerg_req) begin
                  state_d = green_of(emerg_dir);
               end else if (ped_pending_q) begin
                  state_d   = S_WALK;
                  next_ew_d = 1'b1;
               end else begin
                  state_d = S_EWG;
               end
            end
         end
         S_RED_B: begin
            if (at_allred) begin
               if (emerg_req) begin
                  state_d = green_of(emerg_dir);
               end else if (ped_pending_q) begin
                  state_d   = S_WALK;
                  next_ew_d = 1'b0;
               end else begin
                  state_d = S_NSG;
               end
            end
         end
         S_WALK: begin
            if (at_walk) begin
               state_d = emerg_req ? green_of(emerg_dir) : green_of(next_ew_q);
            end
         end
         default: state_d = S_RED_B;
      endcase
   end

   // A request arriving on the walk-entry cycle survives the clear.
   assign ped_pending_d = ped_req ||
                          (ped_pending_q && !(state_d == S_WALK && state_q != S_WALK));
   assign clr = (state_d != state_q);

   // NOTE: reset is synchronous and active-high; only control state is
   // reset, and a mid-phase reset drops any latched pedestrian request.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_RED_B;
         ped_pending_q <= 1'b0;
         next_ew_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         ped_pending_q <= ped_pending_d;
         next_ew_q     <= next_ew_d;
      end
   end

   cnt_in_range: assert property (@(posedge clk) disable iff (reset)
                                  cnt <= CNT_W'(GREEN_MAX - 1));

   assign NS_green  = (state_q == S_NSG);
   assign NS_yellow = (state_q == S_NSY);
   assign NS_red    = !(NS_green || NS_yellow);
   assign EW_green  = (state_q == S_EWG);
   assign EW_yellow = (state_q == S_EWY);
   assign EW_red    = !(EW_green || EW_yellow);
   assign walk      = (state_q == S_WALK);
   assign phase     = state_q;

endmodule
